fila_cmd_gen: RTL and testbench
===============================

// Module: fila_cmd_gen
// PURPOSE
//  Upstream command stage for the 8-entry byte queue (fila). Turns raw push-buttons and
//  switch data into clean, single-cycle enqueue/dequeue requests spaced so the queue is
//  always in its waiting state when sampled. Checks the queue length and rejects
//  overflow/underflow requests locally, so the queue never receives an illegal command.
// PARAMETERS
//  DEB_CYCLES   200  stable cycles for a button change to be accepted (20 ms @ 10 kHz); >=1
//  HOLD_CYCLES  2    idle cycles after each issued request before the next one; must be >=2
//  DEPTH        8    queue capacity, compared against len_in
// PORTS
//  clock_10KHz  in   1  system clock
//  reset        in   1  asynchronous, active-high reset
//  btn_enq_in   in   1  raw enqueue button, asynchronous, may bounce
//  btn_deq_in   in   1  raw dequeue button, asynchronous, may bounce
//  sw_data_in   in   8  byte to enqueue (switches)
//  len_in       in   8  current queue length (queue len_out)
//  enqueue_out  out  1  one-cycle enqueue request to the queue
//  dequeue_out  out  1  one-cycle dequeue request to the queue
//  data_out     out  8  byte presented to queue data_in
//  reject_out   out  1  one-cycle pulse: press refused (full on enqueue / empty on dequeue)
//  busy_out     out  1  high while in ISSUE or WAIT
// BEHAVIOUR
//  Reset: all outputs 0. FSM=IDLE. Synchronisers, debounced levels and counters cleared.
//  Input path, per button: 2-flop synchroniser -> debouncer -> rising-edge detect.
//   - Debouncer: counter runs while the synced level differs from the debounced level.
//     Debounced level flips when the counter reaches DEB_CYCLES. The counter clears on any
//     cycle the levels agree. Width $clog2(DEB_CYCLES+1).
//   - press = one-cycle pulse on the debounced 0->1 transition. Release produces nothing.
//  FSM IDLE / ISSUE / WAIT:
//   - IDLE, enq press, len_in < DEPTH: latch sw_data_in into data_out; go ISSUE (enq).
//   - IDLE, enq press, len_in >= DEPTH: reject_out=1 for 1 cycle; stay IDLE.
//   - IDLE, deq press, no enq press, len_in > 0: go ISSUE (deq). data_out is unchanged.
//   - IDLE, deq press, len_in == 0: reject_out=1 for 1 cycle; stay IDLE.
//   - Simultaneous enq and deq press: enqueue wins. The deq press is discarded, not deferred.
//   - ISSUE: exactly one of enqueue_out/dequeue_out is high for this single cycle. Then go
//     WAIT with hold counter = HOLD_CYCLES.
//   - WAIT: decrement the counter; return to IDLE when it expires. The total gap guarantees
//     the queue has finished its operation and len_in is updated before the next decision.
//   - Presses arriving in ISSUE/WAIT are dropped. No queuing, no reject pulse.
//  Latency: press pulse (cycle t) -> request output high in cycle t+1. Raw edge -> press =
//   2 sync + DEB_CYCLES cycles.
//  data_out holds the last accepted enqueue byte until the next accepted enqueue. It is
//   stable through ISSUE and WAIT.
//  enqueue_out, dequeue_out and reject_out are registered. They are never high together.
//  Reset mid-operation: any pending request is aborted immediately and no pulse is emitted.
//   A button held through reset deasserts to debounced 0, then re-debounces. It yields one
//   press DEB_CYCLES(+2) after release of reset.
// STRUCTURE
//  fila_pkg: state enum (IDLE, ISSUE, WAIT), DATA_W=8, DEPTH default, cmd enum {ENQ, DEQ}.
//  Sub-module btn_debounce (sync + debounce + edge pulse, param DEB_CYCLES), instantiated
//   twice. The top holds the FSM, hold counter, data latch and reject logic.
// TESTING (DEB_CYCLES=4, HOLD_CYCLES=2, fila instance as load)
//  1. Bouncing enq (toggle 3x in 3 cycles, then hold high), sw=0xA5, len=0 -> exactly one
//     enqueue_out pulse, data_out=0xA5, fila len 0->1.
//  2. 8 clean enq presses (0x01..0x08), then 1 more -> 8 pulses, 9th gives reject_out
//     pulse and no enqueue_out. 8 deq presses -> fila data_out 0x01..0x08 in order.
//  3. Deq press with len=0 -> reject_out 1 cycle, dequeue_out stays 0.
//  4. Enq and deq debounced in the same cycle, len=3 -> only enqueue_out, len 3->4.
//  5. Second press landing in WAIT -> ignored, no output pulse, busy_out=1 during it.
//  6. Reset asserted during ISSUE -> enqueue_out drops the same cycle. Button held through
//     reset -> one press DEB_CYCLES+2 cycles after reset release.

Source files
------------

// File: rtl/fila_pkg.sv
// Shared types and sizing for the fila command front end.
package fila_pkg;
    localparam int DATA_W    = 8;
    localparam int DEPTH_DEF = 8;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    typedef enum logic {CMD_ENQ, CMD_DEQ} cmd_t;
endpackage

// File: rtl/btn_debounce.sv
// Raw button -> 2-flop synchroniser -> counter debouncer -> one-cycle press pulse.
module btn_debounce #(
    parameter int DEB_CYCLES = 200
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          sync0;
    logic          sync1;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync0 <= 1'b0;
            sync1 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync0 <= btn;
            sync1 <= sync0;
            press <= 1'b0;
            if (sync1 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_CYCLES - 1)) begin
                // DEB_CYCLES-th consecutive disagreeing cycle: accept the new level
                cnt   <= '0;
                level <= sync1;
                press <= sync1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/fila_cmd_gen.sv
// Turns debounced buttons into spaced, legality-checked enqueue/dequeue requests for fila.
module fila_cmd_gen
    import fila_pkg::*;
#(
    parameter int DEB_CYCLES  = 200,
    parameter int HOLD_CYCLES = 2,
    parameter int DEPTH       = DEPTH_DEF
) (
    input  logic              clock_10KHz,
    input  logic              reset,
    input  logic              btn_enq_in,
    input  logic              btn_deq_in,
    input  logic [DATA_W-1:0] sw_data_in,
    input  logic [DATA_W-1:0] len_in,
    output logic              enqueue_out,
    output logic              dequeue_out,
    output logic [DATA_W-1:0] data_out,
    output logic              reject_out,
    output logic              busy_out
);
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    logic enq_press;
    logic deq_press;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_enq (
        .clk(clock_10KHz), .rst(reset), .btn(btn_enq_in), .press(enq_press)
    );
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_deq (
        .clk(clock_10KHz), .rst(reset), .btn(btn_deq_in), .press(deq_press)
    );

    state_t            state, state_n;
    logic [HW-1:0]     hold, hold_n;
    logic [DATA_W-1:0] data_n;
    logic              enq_n, deq_n, rej_n;

    always_ff @(posedge clock_10KHz or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            hold        <= '0;
            data_out    <= '0;
            enqueue_out <= 1'b0;
            dequeue_out <= 1'b0;
            reject_out  <= 1'b0;
        end else begin
            state       <= state_n;
            hold        <= hold_n;
            data_out    <= data_n;
            enqueue_out <= enq_n;
            dequeue_out <= deq_n;
            reject_out  <= rej_n;
        end
    end

    always_comb begin
        cmd_t pick;
        logic go;
        state_n = state;
        hold_n  = hold;
        data_n  = data_out;
        enq_n   = 1'b0;
        deq_n   = 1'b0;
        rej_n   = 1'b0;
        pick    = CMD_ENQ;
        go      = 1'b0;
        case (state)
            IDLE: begin
                // Enqueue has priority; a simultaneous dequeue press is simply lost
                if (enq_press) begin
                    pick = CMD_ENQ;
                    if (len_in < DATA_W'(DEPTH)) begin
                        go     = 1'b1;
                        data_n = sw_data_in;
                    end else begin
                        rej_n = 1'b1;
                    end
                end else if (deq_press) begin
                    pick = CMD_DEQ;
                    if (len_in != '0) go = 1'b1;
                    else              rej_n = 1'b1;
                end
                if (go) begin
                    state_n = ISSUE;
                    enq_n   = (pick == CMD_ENQ);
                    deq_n   = (pick == CMD_DEQ);
                end
            end
            ISSUE: begin
                state_n = WAIT;
                hold_n  = HW'(HOLD_CYCLES);
            end
            WAIT: begin
                hold_n = hold - 1'b1;
                if (hold <= HW'(1)) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy_out = (state != IDLE);
endmodule

// File: tb/tb_fila_cmd_gen.sv
// Scoreboard bench for fila_cmd_gen driving a behavioural fila queue model as its load.
module tb_fila_cmd_gen;
    localparam int DEB  = 4;
    localparam int HOLD = 2;

    localparam logic [2:0] C_ENQ = 3'b001;
    localparam logic [2:0] C_DEQ = 3'b010;
    localparam logic [2:0] C_REJ = 3'b100;

    typedef struct {
        logic [2:0] code;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_enq = 1'b0;
    logic       btn_deq = 1'b0;
    logic [7:0] sw = '0;
    logic [7:0] len = '0;
    logic       enqueue_out, dequeue_out, reject_out, busy_out;
    logic [7:0] data_out;

    exp_t       sb[$];
    logic [7:0] fila[$];
    int         n_tests = 0;
    int         n_fail = 0;

    fila_cmd_gen #(.DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD), .DEPTH(8)) dut (
        .clock_10KHz(clk), .reset(reset), .btn_enq_in(btn_enq), .btn_deq_in(btn_deq),
        .sw_data_in(sw), .len_in(len), .enqueue_out(enqueue_out), .dequeue_out(dequeue_out),
        .data_out(data_out), .reject_out(reject_out), .busy_out(busy_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_enq(input logic [7:0] v);
        sw = v;
        if (len < 8) sb.push_back('{C_ENQ, v});
        else         sb.push_back('{C_REJ, 8'h00});
        btn_enq = 1'b1;
        tick(10);
        btn_enq = 1'b0;
        tick(12);
    endtask

    task automatic press_deq(input logic [7:0] exp_byte);
        if (len > 0) sb.push_back('{C_DEQ, exp_byte});
        else         sb.push_back('{C_REJ, 8'h00});
        btn_deq = 1'b1;
        tick(10);
        btn_deq = 1'b0;
        tick(12);
    endtask

    // Output monitor: pops the scoreboard on every pulse and plays the fila load
    initial begin
        logic [2:0] code;
        exp_t       e;
        logic [7:0] d;
        forever begin
            @(negedge clk);
            if (!reset) begin
                code = {reject_out, dequeue_out, enqueue_out};
                if (code != 3'b000) begin
                    chk("onehot", $countones(code), 1);
                    if (sb.size() == 0) begin
                        chk("unexpected_pulse", {29'd0, code}, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("kind", {29'd0, code}, {29'd0, e.code});
                        if (enqueue_out) begin
                            chk("enq_data", {24'd0, data_out}, {24'd0, e.data});
                            fila.push_back(data_out);
                        end
                        if (dequeue_out) begin
                            d = (fila.size() > 0) ? fila.pop_front() : 8'hxx;
                            chk("deq_data", {24'd0, d}, {24'd0, e.data});
                        end
                    end
                    len = 8'(fila.size());
                end
            end
        end
    end

    initial begin
        int n;
        logic found;
        // reset state
        tick(3);
        chk("rst_enq", {31'd0, enqueue_out}, 0);
        chk("rst_deq", {31'd0, dequeue_out}, 0);
        chk("rst_rej", {31'd0, reject_out}, 0);
        chk("rst_busy", {31'd0, busy_out}, 0);
        chk("rst_data", {24'd0, data_out}, 0);
        reset = 1'b0;
        tick(2);

        // 1: bouncing enqueue button
        sw = 8'hA5;
        sb.push_back('{C_ENQ, 8'hA5});
        btn_enq = 1'b1; tick(1);
        btn_enq = 1'b0; tick(1);
        btn_enq = 1'b1; tick(1);
        btn_enq = 1'b0; tick(1);
        btn_enq = 1'b1;
        tick(14);
        chk("t1_data", {24'd0, data_out}, 32'hA5);
        chk("t1_len", {24'd0, len}, 1);
        btn_enq = 1'b0;
        tick(12);
        press_deq(8'hA5);

        // 2: fill to capacity, overflow reject, drain in order
        for (int i = 1; i <= 8; i++) press_enq(8'(i));
        chk("t2_full", {24'd0, len}, 8);
        press_enq(8'hEE);
        chk("t2_data_kept", {24'd0, data_out}, 32'h08);
        for (int i = 1; i <= 8; i++) press_deq(8'(i));
        chk("t2_empty", {24'd0, len}, 0);

        // 3: underflow reject
        press_deq(8'h00);
        chk("t3_len", {24'd0, len}, 0);

        // 4: simultaneous presses, enqueue wins
        press_enq(8'h10);
        press_enq(8'h11);
        press_enq(8'h12);
        sw = 8'h33;
        sb.push_back('{C_ENQ, 8'h33});
        btn_enq = 1'b1;
        btn_deq = 1'b1;
        tick(10);
        btn_enq = 1'b0;
        btn_deq = 1'b0;
        tick(12);
        chk("t4_len", {24'd0, len}, 4);

        // 5: dequeue press landing in WAIT is dropped
        sw = 8'h44;
        sb.push_back('{C_ENQ, 8'h44});
        btn_enq = 1'b1;
        tick(2);
        btn_deq = 1'b1;
        tick(6);
        @(negedge clk);
        chk("t5_busy", {31'd0, busy_out}, 1);
        chk("t5_no_deq", {31'd0, dequeue_out}, 0);
        chk("t5_data_stable", {24'd0, data_out}, 32'h44);
        tick(4);
        btn_enq = 1'b0;
        btn_deq = 1'b0;
        tick(12);
        chk("t5_len", {24'd0, len}, 5);

        // 6: reset during ISSUE, button held through reset
        sw = 8'h55;
        btn_enq = 1'b1;
        tick(7);
        chk("t6_issue", {31'd0, enqueue_out}, 1);
        #1;
        reset = 1'b1;
        #1;
        chk("t6_abort", {31'd0, enqueue_out}, 0);
        chk("t6_busy", {31'd0, busy_out}, 0);
        fila.delete();
        len = '0;
        tick(3);
        sw = 8'h66;
        sb.push_back('{C_ENQ, 8'h66});
        reset = 1'b0;
        n = 0;
        found = 1'b0;
        for (int i = 1; i <= 20 && !found; i++) begin
            @(posedge clk);
            #1;
            if (enqueue_out) begin
                found = 1'b1;
                n = i;
            end
        end
        chk("t6_press_latency", n, DEB + 3);
        btn_enq = 1'b0;
        tick(12);
        chk("t6_len", {24'd0, len}, 1);

        chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
